// File: rtl/fx2_pkg.sv
// Shared constants for the slave-FIFO emulator.
package fx2_pkg;

  localparam logic [1:0] EP2_ADDR = 2'b00;
  localparam logic [1:0] EP6_ADDR = 2'b10;

  localparam int ERR_UNDERFLOW = 0;
  localparam int ERR_OVERFLOW  = 1;
  localparam int ERR_CONFLICT  = 2;

  localparam int PKT_WORDS_DEF = 256;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
module sync_fifo_fwft #(
  parameter int W  = 16,
  parameter int AW = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic [W-1:0]  rdata_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rptr_q];
  assign count_o = cnt_q;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  // Storage needs no reset; only pointers define contents.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/fx2_slave_fifo_emu.sv
// Device-side slave-FIFO emulator: EP2 OUT source, EP6 IN sink,
// with packet commit tracking and a host-side access port.
module fx2_slave_fifo_emu
  import fx2_pkg::*;
#(
  parameter int IN_AW     = 10,
  parameter int OUT_AW    = 4,
  parameter int PKT_WORDS = PKT_WORDS_DEF
) (
  input  logic              i_clk_usb,
  input  logic              i_rst_n,
  input  logic              i_slcs,
  input  logic [1:0]        i_addr,
  input  logic              i_sloe,
  input  logic              i_slrd,
  input  logic              i_slwr,
  input  logic              i_slpked,
  inout  wire  [15:0]       io_data,
  output logic              o_flagb,
  output logic              o_flagc,
  input  logic              i_host_wr,
  input  logic [15:0]       i_host_wdata,
  output logic              o_host_full,
  input  logic              i_host_rd,
  output logic [15:0]       o_host_rdata,
  output logic              o_host_rvalid,
  output logic [IN_AW:0]    o_in_committed,
  output logic              o_zlp,
  output logic [2:0]        o_err
);

  localparam int IN_DEPTH  = 1 << IN_AW;
  localparam int OUT_DEPTH = 1 << OUT_AW;

  logic sel_out, sel_in;
  assign sel_out = ~i_slcs & (i_addr == EP2_ADDR);
  assign sel_in  = ~i_slcs & (i_addr == EP6_ADDR);

  // EP2 OUT path
  logic [15:0]     ep2_head;
  logic [OUT_AW:0] ep2_cnt, ep2_cnt_d;
  logic            ep2_full, ep2_empty;
  logic            ep2_push, ep2_pop, rd_req;
  logic [15:0]     last_q, last_d;

  assign rd_req   = sel_out & ~i_slrd;
  assign ep2_pop  = rd_req & ~ep2_empty;
  assign ep2_push = i_host_wr & ~ep2_full;

  sync_fifo_fwft #(.W(16), .AW(OUT_AW)) u_ep2 (
    .clk_i   (i_clk_usb),
    .rst_ni  (i_rst_n),
    .push_i  (ep2_push),
    .wdata_i (i_host_wdata),
    .pop_i   (ep2_pop),
    .rdata_o (ep2_head),
    .count_o (ep2_cnt),
    .full_o  (ep2_full),
    .empty_o (ep2_empty)
  );

  assign io_data = (sel_out & ~i_sloe)
                 ? (ep2_empty ? last_q : ep2_head)
                 : 16'hzzzz;

  // EP6 IN path
  logic [15:0]    ep6_head;
  logic [IN_AW:0] ep6_cnt;
  logic           ep6_full, ep6_empty;
  logic           wr_req, ep6_push, host_pop;
  logic [IN_AW:0] committed_q, committed_d;
  logic [IN_AW:0] pend, pend_new, commit_amt, used_d;
  logic           slpked_q, pkt_fall;

  assign wr_req   = sel_in & ~i_slwr;
  assign ep6_push = wr_req & ~ep6_full;
  assign host_pop = i_host_rd & (committed_q != '0) & ~ep6_empty;

  sync_fifo_fwft #(.W(16), .AW(IN_AW)) u_ep6 (
    .clk_i   (i_clk_usb),
    .rst_ni  (i_rst_n),
    .push_i  (ep6_push),
    .wdata_i (io_data),
    .pop_i   (host_pop),
    .rdata_o (ep6_head),
    .count_o (ep6_cnt),
    .full_o  (ep6_full),
    .empty_o (ep6_empty)
  );

  assign pkt_fall = slpked_q & ~i_slpked & ~i_slcs;

  logic            flagb_d, flagc_d, hfull_d, zlp_d;
  logic [2:0]      err_q, err_d;
  logic            flagb_q, flagc_q, hfull_q, zlp_q;
  logic [15:0]     rdata_q, rdata_d;
  logic            rvalid_q;

  always_comb begin
    pend       = ep6_cnt - committed_q;
    pend_new   = pend + (IN_AW+1)'(ep6_push);
    commit_amt = '0;
    zlp_d      = 1'b0;
    // A write on the pktend edge joins the packet being closed.
    if (pkt_fall) begin
      if (pend_new == '0) zlp_d = 1'b1;
      else                commit_amt = pend_new;
    end else if (pend_new == (IN_AW+1)'(PKT_WORDS)) begin
      commit_amt = pend_new;
    end
    committed_d = committed_q - (IN_AW+1)'(host_pop) + commit_amt;
    used_d      = ep6_cnt + (IN_AW+1)'(ep6_push)
                - (IN_AW+1)'(host_pop);
    flagb_d     = used_d < (IN_AW+1)'(IN_DEPTH);
    ep2_cnt_d   = ep2_cnt + (OUT_AW+1)'(ep2_push)
                - (OUT_AW+1)'(ep2_pop);
    flagc_d     = ep2_cnt_d != '0;
    hfull_d     = ep2_cnt_d == (OUT_AW+1)'(OUT_DEPTH);
    last_d      = ep2_pop ? ep2_head : last_q;
    rdata_d     = host_pop ? ep6_head : rdata_q;
    err_d       = err_q;
    if (rd_req & ep2_empty)     err_d[ERR_UNDERFLOW] = 1'b1;
    if (wr_req & ep6_full)      err_d[ERR_OVERFLOW]  = 1'b1;
    if (~i_slcs & ~i_sloe & ~i_slwr) err_d[ERR_CONFLICT] = 1'b1;
  end

  always_ff @(posedge i_clk_usb or negedge i_rst_n) begin
    if (!i_rst_n) begin
      committed_q <= '0;
      slpked_q    <= 1'b1;
      last_q      <= '0;
      flagb_q     <= 1'b1;
      flagc_q     <= 1'b0;
      hfull_q     <= 1'b0;
      zlp_q       <= 1'b0;
      err_q       <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
    end else begin
      committed_q <= committed_d;
      slpked_q    <= i_slpked;
      last_q      <= last_d;
      flagb_q     <= flagb_d;
      flagc_q     <= flagc_d;
      hfull_q     <= hfull_d;
      zlp_q       <= zlp_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= host_pop;
    end
  end

  assign o_flagb        = flagb_q;
  assign o_flagc        = flagc_q;
  assign o_host_full    = hfull_q;
  assign o_zlp          = zlp_q;
  assign o_err          = err_q;
  assign o_host_rdata   = rdata_q;
  assign o_host_rvalid  = rvalid_q;
  assign o_in_committed = committed_q;

endmodule
